// File: rtl/barrel_shifter_pkg.sv
// Shared types, sizes and helpers for the pipelined barrel shifter.
// BARREL_SHIFTER_ROTATE_EN enables the ROTATE mode; otherwise ROTATE behaves as LOGIC.
package barrel_shifter_pkg;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned LOG2W       = $clog2(WIDTH);
  localparam int unsigned STAGE_TAG_W = 4;

`ifdef BARREL_SHIFTER_ROTATE_EN
  localparam bit RotateEn = 1'b1;
`else
  localparam bit RotateEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    ModeLogic  = 2'd0,
    ModeArith  = 2'd1,
    ModeRotate = 2'd2,
    ModeRsvd   = 2'd3
  } shift_mode_e;

  typedef logic [STAGE_TAG_W-1:0] tag_t;

  typedef struct packed {
    logic              vld;
    logic [WIDTH-1:0]  data;
    logic [LOG2W-1:0]  shamt;
    logic              dir;
    shift_mode_e       mode;
    logic              fill;
    tag_t              tag;
  } shift_stage_t;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < int'(WIDTH); i++) begin
      r[i] = d[int'(WIDTH) - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational level of the left-shift network: shift by SHIFT when en is set.
// Wrap-around muxes exist only when BARREL_SHIFTER_ROTATE_EN is defined.
module shift_level
  import barrel_shifter_pkg::*;
#(
  parameter int unsigned SHIFT = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             fill,
  input  logic             rotate,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] shifted;

`ifdef BARREL_SHIFTER_ROTATE_EN
  assign shifted = rotate ? {data[WIDTH-SHIFT-1:0], data[WIDTH-1 -: SHIFT]}
                          : {data[WIDTH-SHIFT-1:0], {SHIFT{fill}}};
`else
  logic unused_rotate;
  assign unused_rotate = rotate;
  assign shifted = {data[WIDTH-SHIFT-1:0], {SHIFT{fill}}};
`endif

  assign result = en ? shifted : data;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter with valid/ready on both sides and synchronous flush.
// Optional rotate mode is enabled by defining BARREL_SHIFTER_ROTATE_EN.
module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter int unsigned REG_EVERY = 2,
  parameter int unsigned TAG_W     = STAGE_TAG_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic [LOG2W-1:0] shamt_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int unsigned NSTG = (LOG2W + REG_EVERY - 1) / REG_EVERY;

  // Registered stage s holds the result of levels [s*REG_EVERY, last level of group s].
  function automatic shift_stage_t finish_stage(input shift_stage_t     src,
                                                input logic [WIDTH-1:0] res,
                                                input logic             last);
    shift_stage_t r;
    r = src;
    // Right shifts run through the left network on reversed data; undo before the final register.
    r.data = (last && src.dir) ? bit_rev(res) : res;
    return r;
  endfunction

  shift_stage_t                         in_stage;
  shift_stage_t [NSTG-1:0]              stage_src;
  shift_stage_t [NSTG-1:0]              stage_res;
  shift_stage_t [NSTG-1:0]              stage_q;
  logic         [NSTG-1:0]              adv;
  logic         [LOG2W-1:0][WIDTH-1:0]  lvl_in;
  logic         [LOG2W-1:0][WIDTH-1:0]  lvl_out;
  logic         [LOG2W-1:0]             lvl_en;
  logic         [LOG2W-1:0]             lvl_fill;
  logic         [LOG2W-1:0]             lvl_rot;

  always_comb begin
    in_stage       = '0;
    in_stage.vld   = valid_i && ready_o;
    in_stage.data  = dir_i ? bit_rev(data_i) : data_i;
    in_stage.shamt = shamt_i;
    in_stage.dir   = dir_i;
    in_stage.mode  = shift_mode_e'(mode_i);
    in_stage.fill  = dir_i && (shift_mode_e'(mode_i) == ModeArith) && data_i[WIDTH-1];
    in_stage.tag   = tag_t'(tag_i);
  end

  // A stage moves when it is empty or the stage after it moves.
  always_comb begin
    adv         = '0;
    adv[NSTG-1] = !stage_q[NSTG-1].vld || ready_i;
    for (int s = int'(NSTG) - 2; s >= 0; s--) begin
      adv[s] = !stage_q[s].vld || adv[s+1];
    end
  end

  assign ready_o = adv[0] && !flush_i;

  for (genvar k = 0; k < int'(LOG2W); k++) begin : g_level
    localparam int unsigned Grp = k / REG_EVERY;

    if (k % REG_EVERY == 0) begin : g_head
      assign lvl_in[k] = stage_src[Grp].data;
    end else begin : g_chain
      assign lvl_in[k] = lvl_out[k-1];
    end

    assign lvl_en[k]   = stage_src[Grp].shamt[k];
    assign lvl_fill[k] = stage_src[Grp].fill;
    assign lvl_rot[k]  = RotateEn && (stage_src[Grp].mode == ModeRotate);

    shift_level #(
      .SHIFT (2 ** k)
    ) u_level (
      .data   (lvl_in[k]),
      .en     (lvl_en[k]),
      .fill   (lvl_fill[k]),
      .rotate (lvl_rot[k]),
      .result (lvl_out[k])
    );
  end

  for (genvar s = 0; s < int'(NSTG); s++) begin : g_stage
    localparam int unsigned LastLvl = ((s + 1) * REG_EVERY < LOG2W) ?
                                      (s + 1) * REG_EVERY - 1 : LOG2W - 1;
    localparam bit IsLast = (s == int'(NSTG) - 1);

    shift_stage_t q;

    if (s == 0) begin : g_src_in
      assign stage_src[s] = in_stage;
    end else begin : g_src_reg
      assign stage_src[s] = stage_q[s-1];
    end

    assign stage_res[s] = finish_stage(stage_src[s], lvl_out[LastLvl], IsLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        q <= '0;
      end else begin
        if (adv[s]) begin
          q <= stage_res[s];
        end
        if (flush_i) begin
          q.vld <= 1'b0;
        end
      end
    end

    assign stage_q[s] = q;
  end

  assign valid_o = stage_q[NSTG-1].vld;
  assign data_o  = stage_q[NSTG-1].data;
  assign tag_o   = TAG_W'(stage_q[NSTG-1].tag);

  // Control fields of the last stage are carried but never consumed.
  logic unused_last;
  assign unused_last = ^{stage_q[NSTG-1].shamt, stage_q[NSTG-1].dir,
                         stage_q[NSTG-1].mode, stage_q[NSTG-1].fill};

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Pipelined, parametrised successor to the combinational barrel shifter. It performs logical and arithmetic shifts in both directions, plus an optional rotate, over a log2(WIDTH)-level shift network. Pipeline registers sit every REG_EVERY levels, and valid/ready handshakes on both sides allow full-throughput streaming with backpressure and flush. It sits in the datapath between an issue stage and a writeback or result stage.

## Interface
- WIDTH, 32, data width; power of two, ≥ 2 (from barrel_shifter_pkg)
- REG_EVERY, 2, shift levels per pipeline register; 1..LOG2W
- TAG_W, 4, sideband tag width, carried alongside the data
- clk_i  input  1  clock; all state on rising edge
- rst_ni  input  1  asynchronous, active-low reset
- flush_i  input  1  synchronous flush of all in-flight ops
- valid_i  input  1  input op valid
- ready_o  output  1  pipeline can accept an op this cycle
- data_i  input  WIDTH  operand
- shamt_i  input  LOG2W  shift amount, 0..WIDTH-1
- dir_i  input  1  0: left, 1: right
- mode_i  input  2  shift_mode_e: 0 LOGIC, 1 ARITH, 2 ROTATE, 3 reserved
- tag_i  input  TAG_W  sideband, returned unmodified
- valid_o  output  1  result valid
- ready_i  input  1  downstream accepts result
- data_o  output  WIDTH  result
- tag_o  output  TAG_W  tag of the result

## Operation
- LOG2W = $clog2(WIDTH). NSTG = ceil(LOG2W/REG_EVERY) register stages.
- Level k shifts by 2^k when shamt bit k is set. Levels are applied in order k = 0..LOG2W-1.
- Right shifts are implemented as: bit-reverse operand, left network, bit-reverse result. The fill bit is selected per mode.
- Fill rules:
  - LOGIC fills with 0.
  - ARITH right fills with data_i[WIDTH-1].
  - ARITH left is identical to LOGIC left.
  - ROTATE: bits shifted out re-enter at the opposite end.
- mode 3 behaves as LOGIC.
- shamt = 0 returns data_i unchanged in every mode.
- Per-stage state: vld, partial data, remaining shamt bits, dir, mode, fill bit, tag.
- Handshake and stalls:
  - Stage s advances when vld[s] = 0 or stage s+1 advances. The last stage advances when ready_i = 1.
  - ready_o = stage 0 advances and !flush_i.
  - An input transfer occurs when valid_i && ready_o. An output transfer occurs when valid_o && ready_i.
  - A stalled stage holds all its fields unchanged.
- valid_o = vld[NSTG-1]. data_o and tag_o come directly from the last-stage registers, with no logic after the register.
- flush_i:
  - Clears every vld at the next edge.
  - An input presented in the same cycle is not accepted, because ready_o = 0.
  - Data registers need not clear.
- Ordering is strictly FIFO. There is no reordering and no drop except by flush.

## Timing
- Reset (rst_ni = 0, async): all vld = 0; data, tag and control registers = 0.
  - valid_o = 0, data_o = 0, tag_o = 0.
  - ready_o = 1 once rst_ni = 1 and flush_i = 0.
- Latency: an op accepted at edge t appears on valid_o after edge t+NSTG-1, i.e. NSTG cycles after acceptance, when there is no stall.
- Throughput: 1 op/cycle while ready_i = 1.
- Backpressure:
  - ready_o depends combinationally on ready_i through the stage chain.
  - With ready_i = 0 and all stages full, ready_o = 0.
  - Releasing ready_i resumes flow with no bubble and no data loss.
- Simultaneous input accept and output transfer in one cycle is allowed.
- Reset asserted mid-operation discards all in-flight ops immediately and asynchronously.

## Configuration
- BARREL_SHIFTER_ROTATE_EN defined: mode ROTATE performs rotate-left or rotate-right per dir_i.
- Not defined: ROTATE behaves as LOGIC, and the wrap-around muxes are not synthesised.
- All other behaviour is identical in both builds.

## Structure
- barrel_shifter_pkg holds:
  - WIDTH and LOG2W.
  - typedef shift_mode_e (2-bit enum).
  - typedef shift_stage_t: packed struct of vld, data, shamt, dir, mode, fill, tag.
- Sub-module shift_level: one combinational level. Parameter SHIFT (= 2^k); inputs data, en, fill, rotate. Instantiated LOG2W times from a generate loop; pipeline registers are inserted after every REG_EVERY-th level and after the final level.

## Test plan
Default configuration: WIDTH = 32, REG_EVERY = 2, NSTG = 3, ROTATE_EN defined.
1. Shift modes, back-to-back:
   - data 0x8000_00F0, shamt 4: LOGIC right → 0x0800_000F; ARITH right → 0xF800_000F; LOGIC left → 0x0000_0F00.
   - Each result appears 3 cycles after acceptance.
2. Rotate: data 0x8000_0001, shamt 1.
   - Right → 0xC000_0000; left → 0x0000_0003.
   - Rebuild without the macro: same ops give 0x4000_0000 and 0x0000_0002.
3. Boundaries:
   - shamt 0 → unchanged.
   - shamt 31 ARITH right of 0x8000_0000 → 0xFFFF_FFFF.
   - shamt 31 LOGIC left of 0x0000_0001 → 0x8000_0000.
4. Backpressure:
   - Stream 6 ops tagged 0..5; hold ready_i = 0 for 5 cycles.
   - ready_o drops after 3 ops are accepted; all 6 results and tags emerge in order once ready_i = 1.
5. Flush: 3 ops in flight, pulse flush_i together with valid_i.
   - Next cycle valid_o = 0; that input is not accepted; the next op returns normally after 3 cycles.
6. Reset mid-stream: assert rst_ni = 0 between edges.
   - valid_o, data_o and tag_o go to 0 immediately; nothing in flight emerges after release.
